// File: rtl/sprite_pkg.sv
// Shared state encoding and sprite offset tables for the sprite plotter.
// A sprite is 7 body pixels followed by 3 wing pixels whose set depends on the flap bit.
package sprite_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_NEXT,
        S_FIN
    } state_t;

    localparam int SPRITE_PIXELS = 10;
    localparam int BODY_PIXELS   = 7;
    localparam int WING_PIXELS   = 3;
    localparam logic [3:0] LAST_PIX = 4'(SPRITE_PIXELS - 1);

    localparam logic signed [3:0] BODY_DX [BODY_PIXELS] =
        '{4'sd0, 4'sd0, -4'sd1, -4'sd2, -4'sd3, -4'sd4, -4'sd5};
    localparam logic signed [3:0] BODY_DY [BODY_PIXELS] =
        '{4'sd0, 4'sd1, 4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd0};

    localparam logic signed [3:0] WUP_DX [WING_PIXELS] = '{-4'sd3, -4'sd4, -4'sd5};
    localparam logic signed [3:0] WUP_DY [WING_PIXELS] = '{4'sd1, 4'sd2, 4'sd3};
    localparam logic signed [3:0] WDN_DX [WING_PIXELS] = '{-4'sd3, -4'sd4, -4'sd5};
    localparam logic signed [3:0] WDN_DY [WING_PIXELS] = '{-4'sd1, -4'sd2, -4'sd3};

endpackage

// File: rtl/sprite_plotter_if.sv
// Frame request inputs and VGA pixel-write outputs of the sprite plotter.
interface sprite_plotter_if #(
    parameter int N_BIRDS = 4
);
    logic                   start;
    logic [8*N_BIRDS-1:0]   bird_x;
    logic [7*N_BIRDS-1:0]   bird_y;
    logic [N_BIRDS-1:0]     bird_en;
    logic [3*N_BIRDS-1:0]   bird_colour;
    logic [7:0]             x;
    logic [6:0]             y;
    logic [2:0]             colour;
    logic                   plot;
    logic                   busy;
    logic                   done;

    modport master (
        output start, bird_x, bird_y, bird_en, bird_colour,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, bird_x, bird_y, bird_en, bird_colour,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/sprite_pixel_gen.sv
// Combinational offset lookup for one sprite pixel plus screen clipping.
// Arithmetic is widened and signed so off-screen results never wrap into view.
module sprite_pixel_gen
    import sprite_pkg::*;
#(
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic [7:0] anchor_x_i,
    input  logic [6:0] anchor_y_i,
    input  logic [3:0] pix_i,
    input  logic       flap_i,
    output logic [7:0] x_o,
    output logic [6:0] y_o,
    output logic       in_bounds_o
);
    logic signed [3:0] dx, dy;
    logic        [1:0] widx;
    logic signed [8:0] sx;
    logic signed [7:0] sy;

    always_comb begin
        widx = 2'(pix_i - 4'd7);
        if (pix_i < 4'(BODY_PIXELS)) begin
            dx = BODY_DX[pix_i[2:0]];
            dy = BODY_DY[pix_i[2:0]];
        end else if (flap_i) begin
            dx = WDN_DX[widx];
            dy = WDN_DY[widx];
        end else begin
            dx = WUP_DX[widx];
            dy = WUP_DY[widx];
        end
        sx = $signed({1'b0, anchor_x_i}) + 9'(dx);
        sy = $signed({1'b0, anchor_y_i}) + 8'(dy);
    end

    assign in_bounds_o = (sx >= 9'sd0) && (sx <= 9'(X_MAX)) &&
                         (sy >= 8'sd0) && (sy <= 8'(Y_MAX));
    assign x_o = sx[7:0];
    assign y_o = sy[6:0];
endmodule

// File: rtl/sprite_plotter.sv
// Redraws up to N_BIRDS bird sprites per frame: erase old position, draw new, per slot.
// Every slot takes a fixed 21 cycles so the frame length never depends on the enables.
module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int         N_BIRDS   = 4,
    parameter int         X_MAX     = 159,
    parameter int         Y_MAX     = 119,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic             clock,
    input  logic             resetn,
    sprite_plotter_if.slave  bus
);
    localparam int SW = (N_BIRDS > 1) ? $clog2(N_BIRDS) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(N_BIRDS - 1);

    state_t state_q, state_d;
    logic [SW-1:0] slot_q;
    logic [3:0]    pix_q;
    logic          flap_q;

    logic [N_BIRDS-1:0][7:0] lx_q, px_q;
    logic [N_BIRDS-1:0][6:0] ly_q, py_q;
    logic [N_BIRDS-1:0][2:0] lcol_q;
    logic [N_BIRDS-1:0]      len_q, pv_q;

    logic [7:0] x_q, ax, gx;
    logic [6:0] y_q, ay, gy;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d, erase, gflap, in_b;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_ERASE;
            S_ERASE: if (pix_q == LAST_PIX) state_d = S_DRAW;
            S_DRAW:  if (pix_q == LAST_PIX) state_d = S_NEXT;
            S_NEXT:  state_d = (slot_q == LAST_SLOT) ? S_FIN : S_ERASE;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Erase replays the previous frame's sprite, so it uses the opposite flap.
    assign erase    = (state_q == S_ERASE);
    assign ax       = erase ? px_q[slot_q] : lx_q[slot_q];
    assign ay       = erase ? py_q[slot_q] : ly_q[slot_q];
    assign gflap    = erase ? ~flap_q : flap_q;
    assign colour_d = erase ? BG_COLOUR : lcol_q[slot_q];
    assign plot_d   = in_b & ((erase & pv_q[slot_q]) |
                              ((state_q == S_DRAW) & len_q[slot_q]));

    sprite_pixel_gen #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_gen (
        .anchor_x_i  (ax),
        .anchor_y_i  (ay),
        .pix_i       (pix_q),
        .flap_i      (gflap),
        .x_o         (gx),
        .y_o         (gy),
        .in_bounds_o (in_b)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            slot_q   <= '0;
            pix_q    <= '0;
            flap_q   <= 1'b0;
            lx_q     <= '0;
            ly_q     <= '0;
            lcol_q   <= '0;
            len_q    <= '0;
            px_q     <= '0;
            py_q     <= '0;
            pv_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            plot_q <= plot_d;
            if (plot_d) begin
                x_q      <= gx;
                y_q      <= gy;
                colour_q <= colour_d;
            end
            case (state_q)
                S_IDLE: if (bus.start) begin
                    lx_q   <= bus.bird_x;
                    ly_q   <= bus.bird_y;
                    len_q  <= bus.bird_en;
                    lcol_q <= bus.bird_colour;
                    slot_q <= '0;
                    pix_q  <= '0;
                end
                S_ERASE, S_DRAW: pix_q <= (pix_q == LAST_PIX) ? 4'd0 : pix_q + 4'd1;
                S_NEXT: begin
                    px_q[slot_q] <= lx_q[slot_q];
                    py_q[slot_q] <= ly_q[slot_q];
                    pv_q[slot_q] <= len_q[slot_q];
                    if (slot_q != LAST_SLOT) slot_q <= slot_q + SW'(1);
                end
                S_FIN: flap_q <= ~flap_q;
                default: ;
            endcase
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_FIN);
endmodule

// File: tb/tb_sprite_plotter.sv
// Directed frames against a per-cycle pixel model built from the sprite rules.
module tb_sprite_plotter;
    localparam int NB = 4;
    localparam int XM = 159;
    localparam int YM = 119;
    localparam logic [2:0] BG = 3'b000;
    localparam int ODX[10]    = '{0, 0, -1, -2, -3, -4, -5, -3, -4, -5};
    localparam int ODY_UP[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 2, 3};
    localparam int ODY_DN[10] = '{0, 1, 0, 0, 0, 0, 0, -1, -2, -3};

    logic clock = 1'b0;
    logic resetn = 1'b0;
    sprite_plotter_if #(.N_BIRDS(NB)) bus();
    sprite_plotter #(.N_BIRDS(NB), .X_MAX(XM), .Y_MAX(YM), .BG_COLOUR(BG)) dut (
        .clock(clock), .resetn(resetn), .bus(bus));
    always #5 clock = ~clock;

    int total = 0, bad = 0;
    int fx[NB], fy[NB], fcol[NB];
    bit [NB-1:0] fen;
    int mpx[NB], mpy[NB];
    bit [NB-1:0] mpv;
    bit mflap;
    bit e_plot[86];
    int e_x[86], e_y[86], e_c[86];
    bit seen[160][120];
    int erase_cnt, draw_cnt, done_cnt, done_at, wrap_cnt;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic build_expect();
        for (int c = 0; c < 86; c++) begin
            int f, s, r, k, ax, ay, x, y, col;
            bit fl, v;
            e_plot[c] = 0; e_x[c] = 0; e_y[c] = 0; e_c[c] = 0;
            if (c >= 1 && c <= 21 * NB) begin
                f = c - 1; s = f / 21; r = f % 21;
                if (r < 20) begin
                    if (r < 10) begin
                        k = r; ax = mpx[s]; ay = mpy[s]; fl = ~mflap; v = mpv[s]; col = int'(BG);
                    end else begin
                        k = r - 10; ax = fx[s]; ay = fy[s]; fl = mflap; v = fen[s]; col = fcol[s];
                    end
                    x = ax + ODX[k];
                    y = ay + (fl ? ODY_DN[k] : ODY_UP[k]);
                    e_plot[c] = v && x >= 0 && x <= XM && y >= 0 && y <= YM;
                    e_x[c] = x; e_y[c] = y; e_c[c] = col;
                end
            end
        end
    endtask

    task automatic run_frame(input int rep_at, input int rst_at);
        bit aborted;
        aborted = 0;
        @(negedge clock);
        for (int i = 0; i < NB; i++) begin
            bus.bird_x[8*i +: 8]      = 8'(fx[i]);
            bus.bird_y[7*i +: 7]      = 7'(fy[i]);
            bus.bird_colour[3*i +: 3] = 3'(fcol[i]);
        end
        bus.bird_en = fen;
        bus.start = 1'b1;
        build_expect();
        erase_cnt = 0; draw_cnt = 0; done_cnt = 0; done_at = -1; wrap_cnt = 0;
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) seen[i][j] = 0;
        @(negedge clock);
        bus.start = 1'b0;
        bus.bird_x = $urandom;
        bus.bird_y = 28'($urandom);
        bus.bird_en = 4'($urandom);
        bus.bird_colour = 12'($urandom);
        for (int c = 0; c <= 85; c++) begin
            if (c > 0) @(negedge clock);
            if (c == rep_at) bus.start = 1'b1;
            else if (c == rep_at + 1) bus.start = 1'b0;
            if (c == rst_at) begin
                #2 resetn = 1'b0;
                #1 chk("async reset outputs", int'({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}), 0);
                @(negedge clock);
                chk("reset busy", int'(bus.busy), 0);
                chk("reset done", int'(bus.done), 0);
                resetn = 1'b1;
                mpv = '0; mflap = 0;
                for (int i = 0; i < NB; i++) begin mpx[i] = 0; mpy[i] = 0; end
                aborted = 1;
                break;
            end
            chk($sformatf("busy c=%0d", c), int'(bus.busy), int'(c <= 21 * NB));
            chk($sformatf("done c=%0d", c), int'(bus.done), int'(c == 21 * NB));
            chk($sformatf("plot c=%0d", c), int'(bus.plot), int'(e_plot[c]));
            if (e_plot[c] && bus.plot) begin
                chk($sformatf("x c=%0d", c), int'(bus.x), e_x[c]);
                chk($sformatf("y c=%0d", c), int'(bus.y), e_y[c]);
                chk($sformatf("colour c=%0d", c), int'(bus.colour), e_c[c]);
            end
            if (bus.done) begin done_cnt++; done_at = c; end
            if (bus.plot) begin
                if (bus.colour == BG) erase_cnt++; else draw_cnt++;
                if (bus.x == 8'd255 || bus.y == 7'd127) wrap_cnt++;
                if (bus.x < 8'd160 && bus.y < 7'd120) seen[bus.x][bus.y] = 1;
            end
        end
        if (!aborted) begin
            for (int i = 0; i < NB; i++) begin mpx[i] = fx[i]; mpy[i] = fy[i]; end
            mpv = fen;
            mflap = ~mflap;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.bird_x = '0; bus.bird_y = '0; bus.bird_en = '0; bus.bird_colour = '0;
        mpv = '0; mflap = 0;
        for (int i = 0; i < NB; i++) begin mpx[i] = 0; mpy[i] = 0; end
        repeat (3) @(negedge clock);
        chk("reset x", int'(bus.x), 0);
        chk("reset y", int'(bus.y), 0);
        chk("reset colour", int'(bus.colour), 0);
        chk("reset plot", int'(bus.plot), 0);
        chk("reset busy/done", int'({bus.busy, bus.done}), 0);
        resetn = 1'b1;

        fx = '{20, 40, 60, 80}; fy = '{50, 10, 20, 30}; fcol = '{7, 1, 2, 3}; fen = 4'b0001;
        run_frame(-1, -1);
        chk("f1 done_at", done_at, 84);
        chk("f1 done count", done_cnt, 1);
        chk("f1 draw count", draw_cnt, 10);
        chk("f1 erase count", erase_cnt, 0);
        chk("f1 px(20,50)", int'(seen[20][50]), 1);
        chk("f1 px(15,50)", int'(seen[15][50]), 1);
        chk("f1 px(17,51)", int'(seen[17][51]), 1);
        chk("f1 px(15,53)", int'(seen[15][53]), 1);

        fx[0] = 21;
        run_frame(-1, -1);
        chk("f2 erase count", erase_cnt, 10);
        chk("f2 draw count", draw_cnt, 10);
        chk("f2 px(18,49)", int'(seen[18][49]), 1);
        chk("f2 px(17,48)", int'(seen[17][48]), 1);
        chk("f2 px(16,47)", int'(seen[16][47]), 1);
        chk("f2 old wing-up (17,51)", int'(seen[17][51]), 1);

        fx = '{50, 60, 70, 100}; fy = '{50, 30, 70, 100}; fcol = '{7, 2, 6, 4}; fen = 4'b1010;
        run_frame(30, -1);
        chk("f3 done count", done_cnt, 1);
        chk("f3 draw count", draw_cnt, 20);
        chk("f3 erase count", erase_cnt, 10);
        chk("f3 slot1 anchor", int'(seen[60][30]), 1);
        chk("f3 slot0 silent", int'(seen[50][50]), 0);
        chk("f3 slot2 silent", int'(seen[70][70]), 0);

        fx[0] = 2; fy[0] = 1; fcol[0] = 6; fen = 4'b0001;
        run_frame(-1, -1);
        chk("f4 draw count", draw_cnt, 4);
        chk("f4 erase count", erase_cnt, 20);
        chk("f4 px(2,1)", int'(seen[2][1]), 1);
        chk("f4 px(2,2)", int'(seen[2][2]), 1);
        chk("f4 px(1,1)", int'(seen[1][1]), 1);
        chk("f4 no wrap", wrap_cnt, 0);

        fx[0] = 80; fy[0] = 80; fen = 4'b1111;
        run_frame(-1, 40);
        chk("f5 no done after reset", done_cnt, 0);

        fx = '{30, 40, 50, 60}; fy = '{60, 60, 60, 60}; fcol = '{5, 5, 5, 5}; fen = 4'b0001;
        run_frame(-1, -1);
        chk("f6 erase count", erase_cnt, 0);
        chk("f6 draw count", draw_cnt, 10);
        chk("f6 wing-up (27,61)", int'(seen[27][61]), 1);
        chk("f6 no wing-down (27,59)", int'(seen[27][59]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
